// File: rtl/mem_pkg.sv
// Shared types and address-field helpers for the arbitrated banked main memory.
package mem_pkg;

  localparam int MEM_LAT = 2;
  localparam int BANK_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY1 = 2'd1,
    ST_BUSY2 = 2'd2
  } port_state_e;

  // Lowest address bit of the line index: byte offset covers one full line.
  function automatic int line_lsb(input int num_bank);
    return $clog2(num_bank * BANK_DW / 8);
  endfunction

  function automatic int thread_lsb(input int num_bank, input int bank_aw);
    return line_lsb(num_bank) + bank_aw;
  endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Per-region arbiter: rotating priority among RT ports, MC only on an idle region or when starved.
module mem_rr_arb #(
  parameter int NUM_RT = 4,
  parameter int PW     = 2
) (
  input  logic [NUM_RT-1:0] i_rt_req,
  input  logic              i_rt_any,
  input  logic [PW-1:0]     i_rr_ptr,
  input  logic              i_mc_req,
  input  logic              i_mc_starve,
  output logic [NUM_RT:0]   o_grant
);

  logic [NUM_RT-1:0] w_rt_gnt;
  logic [PW-1:0]     w_idx;
  logic              w_found;
  logic              w_mc_gnt;

  always_comb begin
    w_rt_gnt = '0;
    w_idx    = '0;
    w_found  = 1'b0;
    // A busy RT port still holding req on this region keeps the MC out unless starved.
    w_mc_gnt = i_mc_req && (i_mc_starve || !i_rt_any);
    if (!w_mc_gnt) begin
      for (int k = 0; k < NUM_RT; k++) begin
        w_idx = PW'((int'(i_rr_ptr) + k) % NUM_RT);
        if (!w_found && i_rt_req[w_idx]) begin
          w_rt_gnt[w_idx] = 1'b1;
          w_found         = 1'b1;
        end
      end
    end
    o_grant = {w_mc_gnt, w_rt_gnt};
  end

endmodule

// File: rtl/ram.sv
// Single-port synchronous RAM bank; dout updates only on an enabled read.
module ram #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_din;
      else      r_dout        <= r_mem[i_addr];
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/mem_main_arb.sv
// Arbitrated banked main memory: NUM_RT ray-tracer ports plus one MC read port over
// NUM_THREAD regions of parallel 32-bit banks, fixed two-cycle request/ready latency.
module mem_main_arb
  import mem_pkg::*;
#(
  parameter int NUM_RT           = 4,
  parameter int NUM_THREAD       = 16,
  parameter int NUM_BANK_PTHREAD = 4,
  parameter int BANK_AW          = 12,
  parameter int MC_STARVE_LIMIT  = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_RT      [NUM_RT],
  input  logic                              we_RT       [NUM_RT],
  input  logic [31:0]                       addr_RT     [NUM_RT],
  input  logic [32*NUM_BANK_PTHREAD-1:0]    data_RT_in  [NUM_RT],
  output logic                              rdy_RT      [NUM_RT],
  output logic [32*NUM_BANK_PTHREAD-1:0]    data_RT_out [NUM_RT],
  input  logic                              re_MC,
  input  logic [31:0]                       addr_MC,
  output logic                              rdy_MC,
  output logic [32*NUM_BANK_PTHREAD-1:0]    data_MC_out
);

  localparam int LW       = BANK_DW * NUM_BANK_PTHREAD;
  localparam int NP       = NUM_RT + 1;
  localparam int MC       = NUM_RT;
  localparam int TW       = $clog2(NUM_THREAD);
  localparam int PW       = $clog2(NUM_RT);
  localparam int CW       = $clog2(MC_STARVE_LIMIT + 1);
  localparam int LINE_LSB = line_lsb(NUM_BANK_PTHREAD);
  localparam int THR_LSB  = thread_lsb(NUM_BANK_PTHREAD, BANK_AW);

  logic               w_req   [NP];
  logic               w_we    [NP];
  logic [31:0]        w_addr  [NP];
  logic [LW-1:0]      w_wdata [NP];
  logic [TW-1:0]      w_thr   [NP];
  logic [BANK_AW-1:0] w_line  [NP];
  logic               w_elig  [NP];
  logic               w_gnt   [NP];
  port_state_e        r_state     [NP];
  port_state_e        w_state_nxt [NP];
  logic [TW-1:0]      r_thr   [NP];
  logic               r_we    [NP];
  logic [LW-1:0]      r_rdata [NP];
  logic [PW-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [CW-1:0]      r_mc_wait;
  logic [NP-1:0]      w_region_gnt [NUM_THREAD];
  logic [LW-1:0]      w_dout       [NUM_THREAD];

  // The MC is treated as port index NUM_RT: a read-only requester.
  always_comb begin
    for (int p = 0; p < NUM_RT; p++) begin
      w_req[p]   = req_RT[p];
      w_we[p]    = we_RT[p];
      w_addr[p]  = addr_RT[p];
      w_wdata[p] = data_RT_in[p];
    end
    w_req[MC]   = re_MC;
    w_we[MC]    = 1'b0;
    w_addr[MC]  = addr_MC;
    w_wdata[MC] = '0;
    for (int p = 0; p < NP; p++) begin
      w_thr[p]  = w_addr[p][THR_LSB +: TW];
      w_line[p] = w_addr[p][LINE_LSB +: BANK_AW];
      w_elig[p] = w_req[p] && (r_state[p] == ST_IDLE);
    end
  end

  for (genvar t = 0; t < NUM_THREAD; t++) begin : g_region
    logic [NUM_RT-1:0]  w_rt_req;
    logic [NUM_RT-1:0]  w_rt_tgt;
    logic               w_mc_req;
    logic               w_en;
    logic               w_wr;
    logic [BANK_AW-1:0] w_ln;
    logic [LW-1:0]      w_din;

    always_comb begin
      w_rt_req = '0;
      w_rt_tgt = '0;
      for (int i = 0; i < NUM_RT; i++) begin
        w_rt_tgt[i] = w_req[i] && (w_thr[i] == TW'(t));
        w_rt_req[i] = w_rt_tgt[i] && w_elig[i];
      end
      w_mc_req = w_elig[MC] && (w_thr[MC] == TW'(t));
    end

    mem_rr_arb #(.NUM_RT(NUM_RT), .PW(PW)) u_arb (
      .i_rt_req    (w_rt_req),
      .i_rt_any    (|w_rt_tgt),
      .i_rr_ptr    (r_rr_ptr),
      .i_mc_req    (w_mc_req),
      .i_mc_starve (r_mc_wait == CW'(MC_STARVE_LIMIT)),
      .o_grant     (w_region_gnt[t])
    );

    always_comb begin
      w_en  = 1'b0;
      w_wr  = 1'b0;
      w_ln  = '0;
      w_din = '0;
      for (int p = 0; p < NP; p++) begin
        if (w_region_gnt[t][p]) begin
          w_en  = 1'b1;
          w_wr  = w_we[p];
          w_ln  = w_line[p];
          w_din = w_wdata[p];
        end
      end
    end

    for (genvar j = 0; j < NUM_BANK_PTHREAD; j++) begin : g_bank
      ram #(.DW(BANK_DW), .AW(BANK_AW)) u_ram (
        .clk    (clk),
        .i_en   (w_en),
        .i_we   (w_wr),
        .i_addr (w_ln),
        .i_din  (w_din[BANK_DW*j +: BANK_DW]),
        .o_dout (w_dout[t][BANK_DW*j +: BANK_DW])
      );
    end
  end

  // Pointer moves past the highest-numbered RT port granted in any region.
  always_comb begin
    w_rr_ptr_nxt = r_rr_ptr;
    for (int p = 0; p < NP; p++) begin
      w_gnt[p] = 1'b0;
      for (int t = 0; t < NUM_THREAD; t++) w_gnt[p] = w_gnt[p] | w_region_gnt[t][p];
    end
    for (int i = 0; i < NUM_RT; i++) begin
      if (w_gnt[i]) w_rr_ptr_nxt = PW'((i + 1) % NUM_RT);
    end
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      w_state_nxt[p] = r_state[p];
      unique case (r_state[p])
        ST_IDLE:  if (w_gnt[p]) w_state_nxt[p] = ST_BUSY1;
        ST_BUSY1: w_state_nxt[p] = ST_BUSY2;
        ST_BUSY2: w_state_nxt[p] = ST_IDLE;
        default:  w_state_nxt[p] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) r_state[p] <= ST_IDLE;
    end else begin
      for (int p = 0; p < NP; p++) r_state[p] <= w_state_nxt[p];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        r_thr[p]   <= '0;
        r_we[p]    <= 1'b0;
        r_rdata[p] <= '0;
      end
      r_rr_ptr  <= '0;
      r_mc_wait <= '0;
    end else begin
      r_rr_ptr <= w_rr_ptr_nxt;
      for (int p = 0; p < NP; p++) begin
        if ((r_state[p] == ST_IDLE) && w_gnt[p]) begin
          r_thr[p] <= w_thr[p];
          r_we[p]  <= w_we[p];
        end
        // Bank dout was loaded at the grant edge; later accesses cannot disturb it before this capture.
        if ((r_state[p] == ST_BUSY1) && !r_we[p]) r_rdata[p] <= w_dout[r_thr[p]];
      end
      if (!re_MC || w_gnt[MC])
        r_mc_wait <= '0;
      else if (w_elig[MC] && (r_mc_wait != CW'(MC_STARVE_LIMIT)))
        r_mc_wait <= r_mc_wait + 1'b1;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RT; p++) begin
      rdy_RT[p]      = (r_state[p] == ST_BUSY2);
      data_RT_out[p] = r_rdata[p];
    end
    rdy_MC      = (r_state[MC] == ST_BUSY2);
    data_MC_out = r_rdata[MC];
  end

endmodule

// File: doc/mem_main_arb.md
Name: mem_main_arb

Overview:
- Parametrised, arbitrated successor to the team's banked main memory.
- NUM_RT ray-tracer ports and one memory-controller (MC) read port share NUM_THREAD thread regions. Each region is NUM_BANK_PTHREAD parallel 32-bit RAM banks, which together form one 128-bit line.
- Ports hitting different regions are served in the same cycle. Collisions on one region are resolved by a rotating round-robin with an MC starvation guard.
- Request/ready handshake with fixed 2-cycle latency.

Parameters:
- NUM_RT, 4: number of ray-tracer ports.
- NUM_THREAD, 16: thread regions; power of two.
- NUM_BANK_PTHREAD, 4: 32-bit banks per region; line width = 32*NUM_BANK_PTHREAD.
- BANK_AW, 12: bank address width (lines per region).
- MC_STARVE_LIMIT, 8: consecutive lost cycles before MC gets absolute priority.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_RT[NUM_RT]  in  1  request valid, held until rdy_RT.
- we_RT[NUM_RT]  in  1  1=write, 0=read.
- addr_RT[NUM_RT]  in  32  byte address.
- data_RT_in[NUM_RT]  in  LW  write line.
- rdy_RT[NUM_RT]  out  1  one-cycle completion pulse.
- data_RT_out[NUM_RT]  out  LW  read line; holds last read value.
- re_MC  in  1  MC read request, held until rdy_MC.
- addr_MC  in  32  MC byte address.
- rdy_MC  out  1  MC completion pulse.
- data_MC_out  out  LW  MC read line; holds last value.

Behaviour:
- Address decode:
  - Byte offset = addr[log2(LW/8)-1:0], ignored.
  - Line = next BANK_AW bits; thread = next log2(NUM_THREAD) bits.
  - Higher bits ignored (aliasing is legal).
- Line layout: all banks of a region use the same bank address; bank j holds line bits [32j+31:32j].
- Per-port FSM:
  - IDLE: req high and granted → BUSY1 (bank access issues this cycle, G).
  - BUSY1 → BUSY2 at the G+1 edge; RAM dout is captured into the output register.
  - BUSY2: rdy asserted for one cycle (G+2) → IDLE.
  - A port is not eligible for grant while in BUSY1/BUSY2.
  - Requester may present the next request in the cycle after rdy.
  - Same FSM for MC.
- Latency: reads and writes both complete with rdy at G+2.
  - Write data reaches RAM at the G edge; a read granted at G+1 or later sees it.
  - data_*_out is unchanged on write completion.
- Arbitration, per region, each cycle:
  - Among eligible RT requesters targeting the region, grant the first at or after the global pointer rr_ptr (mod NUM_RT).
  - rr_ptr advances to (last RT granted anywhere this cycle)+1 when any RT grant occurs; otherwise it holds.
  - MC is granted only if no RT targets its region, unless mc_wait == MC_STARVE_LIMIT. In that case MC wins its region and RT ports lose there this cycle.
  - mc_wait increments each cycle MC is eligible, requesting and not granted; it clears on grant or when re_MC is low.
- Simultaneous events:
  - Ports on distinct regions are all granted in the same cycle.
  - No two accesses ever reach one bank in one cycle.
- Reset values: all rdy 0, data_*_out 0, FSMs IDLE, rr_ptr 0, mc_wait 0.
- Reset mid-operation: in-flight accesses are dropped with no rdy. A write granted before reset assertion has completed in RAM. RAM contents are not cleared.

Decomposition:
- Package mem_pkg:
  - Address field offsets/widths derived from the parameters.
  - Port FSM state enum (IDLE, BUSY1, BUSY2).
  - Latency constant MEM_LAT=2.
- Sub-module mem_rr_arb: one per region. Takes a request vector plus rr_ptr plus MC request/starve, and outputs a one-hot grant.
- Existing ram module is reused for the banks.

Test Plan (defaults; thread = addr[19:16], line = addr[15:4]):
1. Port0 writes 0x0003_0010 with 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 → rdy_RT[0] at G+2. Port1 then reads 0x0003_001C → rdy_RT[1] at G+2 with identical data (offset bits ignored).
2. Ports 0–3 read 0x0000_0000, 0x0001_0000, 0x0002_0000, 0x0003_0000 in the same cycle → all four rdy together at G+2.
3. Ports 0–3 all read thread 7, rr_ptr=2 → grants go to ports 2,3,0,1 on consecutive cycles; rdy follows each grant by 2 cycles.
4. Port0 streams reads to thread 5 while re_MC reads 0x0005_0040 → MC is granted on its 9th requesting cycle (mc_wait=8); port0 loses that cycle only.
5. Write to 0x0004_0020, then pulse rst_n low at G+1 → no rdy. After reset, a read of 0x0004_0020 returns the written data.
6. Port2 writes 0x0006_0000 at cycle G; port3 reads the same line, granted at G+1 → port3 gets the new data.
